// File: rtl/moore_rr_arbiter.sv
// Purpose: Moore round-robin arbiter sharing one resource between N_REQ level requesters, with a hold limit.
// Latency: req sampled at one edge gives gnt right after that edge; each ownership change inserts one idle cycle.
// Backpressure: en=0 blocks new grants only; owners keep the grant while they hold req, unless a waiting requester forces an eviction at the hold limit.
module moore_rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic             preempt
);

  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0]   OWNER_RST = ID_W'(N_REQ - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]        state;
  logic [ID_W-1:0]   owner;
  logic [ID_W-1:0]   last_owner;
  logic [HOLD_W-1:0] hold_cnt;
  logic              preempt_q;

  logic [N_REQ-1:0]   owner_oh;
  logic               owner_req;
  logic               others_req;
  logic [2*N_REQ-1:0] req_dbl;
  logic [2*N_REQ-1:0] req_shift;
  logic [N_REQ-1:0]   req_rot;
  logic               sel_vld;
  logic [ID_W-1:0]    sel_idx;

  // Owner one-hot mask and the two request summaries the GRANT state acts on.
  always_comb begin
    owner_oh   = N_REQ'(1) << owner;
    owner_req  = |(req & owner_oh);
    others_req = |(req & ~owner_oh);
  end

  // Rotate req so bit 0 is the requester right after last_owner, then take the first set bit.
  always_comb begin
    req_dbl   = {req, req};
    req_shift = req_dbl >> (int'(last_owner) + 1);
    req_rot   = req_shift[N_REQ-1:0];
    sel_vld   = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!sel_vld && req_rot[k]) begin
        sel_vld = 1'b1;
        sel_idx = ID_W'((int'(last_owner) + 1 + k) % N_REQ);
      end
    end
  end

  // Arbitration FSM: IDLE picks the next owner, GRANT handles release, eviction and hold counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OWNER_RST;
      hold_cnt   <= '0;
      preempt_q  <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      case (state)
        IDLE: begin
          if (en && sel_vld) begin
            owner    <= sel_idx;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!owner_req) begin
            // Release wins over eviction, so no preempt pulse here.
            state      <= IDLE;
            last_owner <= owner;
            hold_cnt   <= '0;
          end else if (hold_cnt == HOLD_LAST && others_req) begin
            state      <= IDLE;
            last_owner <= owner;
            hold_cnt   <= '0;
            preempt_q  <= 1'b1;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode purely from registered state, so req never reaches gnt combinationally.
  always_comb begin
    busy    = (state == GRANT);
    gnt     = (state == GRANT) ? owner_oh : '0;
    gnt_id  = (state == GRANT) ? owner : '0;
    preempt = preempt_q;
  end

endmodule

// File: tb/tb_moore_rr_arbiter.sv
// Bench for moore_rr_arbiter: scripted scenarios push per-cycle expectations into a queue,
// and a monitor pops one entry after each rising edge and compares all outputs.
// Asynchronous reset behaviour is checked inline inside the scenario tasks.
module tb_moore_rr_arbiter;

  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       preempt;

  int total;
  int bad;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       pre;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  moore_rr_arbiter #(.N_REQ(4), .ID_W(2), .MAX_HOLD(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: one expectation per edge, compared 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      total++;
      if ({gnt, gnt_id, busy, preempt} !== {cur.gnt, cur.id, cur.busy, cur.pre}) begin
        bad++;
        $display("FAIL %s: got gnt=%b id=%0d busy=%b pre=%b, want gnt=%b id=%0d busy=%b pre=%b",
                 cur.tag, gnt, gnt_id, busy, preempt, cur.gnt, cur.id, cur.busy, cur.pre);
      end
    end
  end

  // Drive inputs at the falling edge and queue the outputs expected after the next rising edge.
  task automatic drv(input logic [3:0] r, input logic e, input logic [3:0] eg,
                     input logic [1:0] eid, input logic eb, input logic ep, input string tag);
    exp_t x;
    @(negedge clk);
    req = r;
    en  = e;
    x.gnt = eg; x.id = eid; x.busy = eb; x.pre = ep; x.tag = tag;
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req   = '0;
    en    = 1'b1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b1;
    req   = 4'b1010;
    repeat (2) begin
      @(negedge clk);
      total++;
      if ({gnt, gnt_id, busy, preempt} !== 8'b0) begin
        bad++;
        $display("FAIL reset_outputs: got gnt=%b id=%0d busy=%b pre=%b, want all zero",
                 gnt, gnt_id, busy, preempt);
      end
    end
    reset = 1'b1;
    drv(4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, "first_grant");
    drv(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "first_release");
  endtask

  task automatic test_round_robin();
    logic [3:0] oh;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      oh = 4'b0001 << k;
      for (int c = 0; c < 3; c++)
        drv(4'b1111, 1'b1, oh, 2'(k), 1'b1, 1'b0, "rr_grant");
      drv(4'b1111 & ~oh, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_gap");
    end
    drv(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, "rr_wrap");
    drv(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_end");
  endtask

  task automatic test_hold_limit();
    do_reset();
    drv(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, "hold_grant");
    for (int c = 0; c < 7; c++)
      drv(4'b0101, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, "hold_keep");
    drv(4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, "hold_evict");
    drv(4'b0101, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, "hold_next");
    drv(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "hold_end");
  endtask

  task automatic test_release_at_limit();
    do_reset();
    drv(4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, "rel_grant");
    for (int c = 0; c < 7; c++)
      drv(4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, "rel_keep");
    drv(4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "rel_no_preempt");
    drv(4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, "rel_next");
    drv(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "rel_end");
  endtask

  task automatic test_sole();
    do_reset();
    for (int c = 0; c < 50; c++)
      drv(4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, "sole_hold");
    drv(4'b1010, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, "sole_evict");
    drv(4'b1010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, "sole_next");
    drv(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "sole_end");
  endtask

  task automatic test_enable();
    do_reset();
    for (int c = 0; c < 3; c++)
      drv(4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "en_blocked");
    drv(4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, "en_grant");
    drv(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "en_persist");
    drv(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, "en_persist");
    drv(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "en_release");
    drv(4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "en_stay_idle");
    drv(4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "en_stay_idle");
    drv(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "en_end");
  endtask

  task automatic test_async_reset();
    do_reset();
    drv(4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, "ar_grant0");
    drv(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "ar_release0");
    drv(4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, "ar_grant1");
    drv(4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, "ar_keep1");
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({gnt, gnt_id, busy, preempt} !== 8'b0) begin
      bad++;
      $display("FAIL async_reset: got gnt=%b id=%0d busy=%b pre=%b, want all zero",
               gnt, gnt_id, busy, preempt);
    end
    @(negedge clk);
    req   = '0;
    reset = 1'b1;
    drv(4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, "ar_pointer_reset");
    drv(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "ar_end");
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at time %0t, want finished", $time);
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    en    = 1'b1;
    req   = '0;
    test_reset();
    test_round_robin();
    test_hold_limit();
    test_release_at_limit();
    test_sole();
    test_enable();
    test_async_reset();
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
